// File: rtl/aes3_pkg.sv
// Shared AES3 definitions: scanner FSM encoding and default timing constants
// used by both the input scanner and the receiver.
package aes3_pkg;

  typedef enum logic [1:0] {
    SWITCH    = 2'd0,
    WAIT_LOCK = 2'd1,
    LOCKED    = 2'd2
  } scan_state_t;

  localparam int DEF_RST_CYCLES   = 8;
  localparam int DEF_LOCK_TIMEOUT = 65536;
  localparam int DEF_LOSS_HOLD    = 1024;

endpackage

// File: rtl/aes3_in_mux.sv
// Registered NUM_IN:1 selector feeding the receiver; the receiver
// synchronises its own input, so a single output flop is all that is needed.
module aes3_in_mux #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] aes3_in,
  input  logic [SEL_W-1:0]  sel,
  output logic              aes3_out
);

  always_ff @(posedge clk) begin
    if (reset) aes3_out <= 1'b0;
    else       aes3_out <= aes3_in[sel];
  end

endmodule

// File: rtl/aes3_input_scanner.sv
// AES3 input scanner: resets the receiver on each input switch, waits for lock,
// holds through short dropouts, else scans round-robin. AES3_SCAN_MANUAL_EN adds man_en/man_sel.
module aes3_input_scanner
  import aes3_pkg::*;
#(
  parameter int NUM_IN       = 4,
  parameter int SEL_W        = 2,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOSS_HOLD    = DEF_LOSS_HOLD,
  parameter int CNT_W        = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] aes3_in,
  input  logic              rx_active,
`ifdef AES3_SCAN_MANUAL_EN
  input  logic              man_en,
  input  logic [SEL_W-1:0]  man_sel,
`endif
  output logic              aes3_out,
  output logic              rx_reset,
  output logic [SEL_W-1:0]  sel,
  output logic              locked,
  output logic              switch_pulse,
  output logic              no_signal
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_HOLD - 1);
  localparam logic [SEL_W:0]   FAIL_MAX  = (SEL_W+1)'(NUM_IN);

  scan_state_t      state, state_d;
  logic [CNT_W-1:0] timer, timer_d;
  logic [SEL_W:0]   fail_cnt, fail_d, fail_inc;
  logic [SEL_W-1:0] sel_d, next_sel;
  logic             locked_d, no_signal_d, pulse_d;
  logic             manual_hold;
  logic             man_force;
  logic [SEL_W-1:0] man_idx;

`ifdef AES3_SCAN_MANUAL_EN
  logic             man_en_q;
  logic [SEL_W-1:0] man_sel_q;

  assign man_idx     = ({1'b0, man_sel} >= FAIL_MAX) ? '0 : man_sel;
  assign manual_hold = man_en;
  assign man_force   = man_en && (!man_en_q || (man_idx != man_sel_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      man_en_q  <= 1'b0;
      man_sel_q <= '0;
    end else begin
      man_en_q  <= man_en;
      man_sel_q <= man_idx;
    end
  end
`else
  assign man_idx     = '0;
  assign manual_hold = 1'b0;
  assign man_force   = 1'b0;
`endif

  assign next_sel = (sel == SEL_W'(NUM_IN - 1)) ? '0 : sel + 1'b1;
  assign fail_inc = fail_cnt + 1'b1;
  assign rx_reset = (state == SWITCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SWITCH;
      sel          <= '0;
      timer        <= '0;
      fail_cnt     <= '0;
      locked       <= 1'b0;
      no_signal    <= 1'b0;
      switch_pulse <= 1'b1;
    end else begin
      state        <= state_d;
      sel          <= sel_d;
      timer        <= timer_d;
      fail_cnt     <= fail_d;
      locked       <= locked_d;
      no_signal    <= no_signal_d;
      switch_pulse <= pulse_d;
    end
  end

  always_comb begin
    state_d     = state;
    sel_d       = sel;
    timer_d     = timer;
    fail_d      = fail_cnt;
    locked_d    = locked;
    no_signal_d = no_signal;
    pulse_d     = 1'b0;
    case (state)
      SWITCH: begin
        if (timer == RST_LAST) begin
          timer_d = '0;
          state_d = WAIT_LOCK;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock wins over a timeout landing in the same cycle.
        if (rx_active) begin
          state_d     = LOCKED;
          timer_d     = '0;
          locked_d    = 1'b1;
          fail_d      = '0;
          no_signal_d = 1'b0;
        end else if (timer == TO_LAST) begin
          state_d = SWITCH;
          timer_d = '0;
          pulse_d = 1'b1;
          if (!manual_hold) begin
            sel_d = next_sel;
            if (fail_inc == FAIL_MAX) begin
              no_signal_d = 1'b1;
              fail_d      = '0;
            end else begin
              fail_d = fail_inc;
            end
          end
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      LOCKED: begin
        // Timer counts only the current run of inactive cycles.
        if (rx_active) begin
          timer_d = '0;
        end else if (timer == LOSS_LAST) begin
          state_d  = SWITCH;
          timer_d  = '0;
          locked_d = 1'b0;
          pulse_d  = 1'b1;
          if (!manual_hold) sel_d = next_sel;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: begin
        state_d = SWITCH;
        timer_d = '0;
      end
    endcase
    if (man_force) begin
      state_d  = SWITCH;
      sel_d    = man_idx;
      timer_d  = '0;
      locked_d = 1'b0;
      pulse_d  = 1'b1;
    end
  end

  aes3_in_mux #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .clk      (clk),
    .reset    (reset),
    .aes3_in  (aes3_in),
    .sel      (sel),
    .aes3_out (aes3_out)
  );

endmodule

// File: tb/tb_aes3_input_scanner.sv
// Directed bench for aes3_input_scanner with shortened timing (timeout 64, loss hold 16).
// Define AES3_SCAN_MANUAL_EN to also exercise the manual override.
module tb_aes3_input_scanner;

  localparam int NUM_IN       = 4;
  localparam int SEL_W        = 2;
  localparam int RST_CYCLES   = 8;
  localparam int LOCK_TIMEOUT = 64;
  localparam int LOSS_HOLD    = 16;
  localparam int CNT_W        = 7;
  localparam int PERIOD       = RST_CYCLES + LOCK_TIMEOUT;

  logic              clk;
  logic              reset;
  logic [NUM_IN-1:0] aes3_in;
  logic              rx_active;
  logic              aes3_out;
  logic              rx_reset;
  logic [SEL_W-1:0]  sel;
  logic              locked;
  logic              switch_pulse;
  logic              no_signal;
`ifdef AES3_SCAN_MANUAL_EN
  logic              man_en;
  logic [SEL_W-1:0]  man_sel;
`endif

  int errors = 0;
  int checks = 0;

  aes3_input_scanner #(
    .NUM_IN       (NUM_IN),
    .SEL_W        (SEL_W),
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOSS_HOLD    (LOSS_HOLD),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .aes3_in      (aes3_in),
    .rx_active    (rx_active),
`ifdef AES3_SCAN_MANUAL_EN
    .man_en       (man_en),
    .man_sel      (man_sel),
`endif
    .aes3_out     (aes3_out),
    .rx_reset     (rx_reset),
    .sel          (sel),
    .locked       (locked),
    .switch_pulse (switch_pulse),
    .no_signal    (no_signal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (rx_reset !== 1'b1) begin errors++; $display("FAIL reset_rx_reset got=%b exp=1", rx_reset); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL reset_no_signal got=%b exp=0", no_signal); end
    checks++; if (switch_pulse !== 1'b1) begin errors++; $display("FAIL reset_pulse got=%b exp=1", switch_pulse); end
    n = 0;
    while (rx_reset === 1'b1 && n < 40) begin
      n++;
      tick(1);
    end
    checks++; if (n != RST_CYCLES) begin errors++; $display("FAIL reset_pulse_len got=%0d exp=%0d", n, RST_CYCLES); end
  endtask

  // No input locks: sel walks 0->1->2->3->0, no_signal after the 4th timeout.
  task automatic test_scan();
    tick(LOCK_TIMEOUT - 1);
    for (int i = 1; i <= NUM_IN; i++) begin
      checks++; if (sel !== SEL_W'(i - 1) || rx_reset !== 1'b0 || switch_pulse !== 1'b0) begin
        errors++; $display("FAIL scan_pre_%0d sel=%0d rx_reset=%b pulse=%b exp sel=%0d rx_reset=0 pulse=0", i, sel, rx_reset, switch_pulse, i - 1);
      end
      tick(1);
      checks++; if (sel !== SEL_W'(i % NUM_IN) || rx_reset !== 1'b1 || switch_pulse !== 1'b1) begin
        errors++; $display("FAIL scan_post_%0d sel=%0d rx_reset=%b pulse=%b exp sel=%0d rx_reset=1 pulse=1", i, sel, rx_reset, switch_pulse, i % NUM_IN);
      end
      checks++; if (no_signal !== (i == NUM_IN)) begin
        errors++; $display("FAIL scan_no_signal_%0d got=%b exp=%b", i, no_signal, i == NUM_IN);
      end
      if (i < NUM_IN) tick(PERIOD - 1);
    end
  endtask

  task automatic test_lock();
    tick(2 * PERIOD);
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL lock_reach_sel got=%0d exp=2", sel); end
    tick(RST_CYCLES + 30);
    checks++; if (locked !== 1'b0 || no_signal !== 1'b1) begin
      errors++; $display("FAIL lock_before locked=%b no_signal=%b exp locked=0 no_signal=1", locked, no_signal);
    end
    rx_active = 1'b1;
    tick(1);
    checks++; if (locked !== 1'b1 || sel !== 2'd2 || no_signal !== 1'b0) begin
      errors++; $display("FAIL lock_after locked=%b sel=%0d no_signal=%b exp 1/2/0", locked, sel, no_signal);
    end
  endtask

  task automatic test_mux();
    aes3_in = 4'b0100;
    tick(1);
    checks++; if (aes3_out !== 1'b1) begin errors++; $display("FAIL mux_hi got=%b exp=1", aes3_out); end
    aes3_in = 4'b1011;
    tick(1);
    checks++; if (aes3_out !== 1'b0) begin errors++; $display("FAIL mux_lo got=%b exp=0", aes3_out); end
  endtask

  task automatic test_short_dropout();
    logic bad;
    bad = 1'b0;
    rx_active = 1'b0;
    for (int i = 0; i < LOSS_HOLD - 1; i++) begin
      tick(1);
      if (switch_pulse !== 1'b0 || locked !== 1'b1) bad = 1'b1;
    end
    rx_active = 1'b1;
    tick(1);
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL short_drop_glitch got=%b exp=0", bad); end
    checks++; if (locked !== 1'b1 || sel !== 2'd2 || rx_reset !== 1'b0) begin
      errors++; $display("FAIL short_drop_end locked=%b sel=%0d rx_reset=%b exp 1/2/0", locked, sel, rx_reset);
    end
  endtask

  task automatic test_long_dropout();
    int n;
    rx_active = 1'b0;
    tick(LOSS_HOLD - 1);
    checks++; if (locked !== 1'b1 || sel !== 2'd2) begin
      errors++; $display("FAIL long_drop_hold locked=%b sel=%0d exp 1/2", locked, sel);
    end
    tick(1);
    checks++; if (locked !== 1'b0 || sel !== 2'd3 || switch_pulse !== 1'b1) begin
      errors++; $display("FAIL long_drop_switch locked=%b sel=%0d pulse=%b exp 0/3/1", locked, sel, switch_pulse);
    end
    n = 0;
    while (rx_reset === 1'b1 && n < 40) begin
      n++;
      tick(1);
      if (n == 1) begin
        checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL long_drop_pulse_width got=%b exp=0", switch_pulse); end
      end
    end
    checks++; if (n != RST_CYCLES) begin errors++; $display("FAIL long_drop_rx_reset_len got=%0d exp=%0d", n, RST_CYCLES); end
  endtask

  // Lock arrives in the same cycle as the last timeout count.
  task automatic test_lock_at_timeout();
    tick(LOCK_TIMEOUT - 1);
    rx_active = 1'b1;
    tick(1);
    checks++; if (locked !== 1'b1 || sel !== 2'd3 || switch_pulse !== 1'b0 || rx_reset !== 1'b0) begin
      errors++; $display("FAIL lock_at_timeout locked=%b sel=%0d pulse=%b rx_reset=%b exp 1/3/0/0", locked, sel, switch_pulse, rx_reset);
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (sel !== 2'd0 || rx_reset !== 1'b1 || locked !== 1'b0 || switch_pulse !== 1'b1) begin
      errors++; $display("FAIL mid_reset sel=%0d rx_reset=%b locked=%b pulse=%b exp 0/1/0/1", sel, rx_reset, locked, switch_pulse);
    end
  endtask

`ifdef AES3_SCAN_MANUAL_EN
  task automatic test_manual();
    rx_active = 1'b0;
    man_sel = 2'd2;
    man_en = 1'b1;
    tick(1);
    checks++; if (sel !== 2'd2 || switch_pulse !== 1'b1) begin errors++; $display("FAIL man_force2 sel=%0d pulse=%b exp 2/1", sel, switch_pulse); end
    tick(RST_CYCLES);
    rx_active = 1'b1;
    tick(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL man_lock2 got=%b exp=1", locked); end
    rx_active = 1'b0;
    man_sel = 2'd1;
    tick(1);
    checks++; if (sel !== 2'd1 || locked !== 1'b0 || rx_reset !== 1'b1 || switch_pulse !== 1'b1) begin
      errors++; $display("FAIL man_switch1 sel=%0d locked=%b rx_reset=%b pulse=%b exp 1/0/1/1", sel, locked, rx_reset, switch_pulse);
    end
    for (int i = 0; i < 2; i++) begin
      tick(PERIOD);
      checks++; if (sel !== 2'd1 || switch_pulse !== 1'b1) begin
        errors++; $display("FAIL man_timeout_%0d sel=%0d pulse=%b exp 1/1", i, sel, switch_pulse);
      end
    end
    tick(RST_CYCLES + 10);
    reset = 1'b1;
    man_en = 1'b0;
    tick(1);
    reset = 1'b0;
    checks++; if (sel !== 2'd0 || rx_reset !== 1'b1) begin errors++; $display("FAIL man_reset sel=%0d rx_reset=%b exp 0/1", sel, rx_reset); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    aes3_in = '0;
    rx_active = 1'b0;
`ifdef AES3_SCAN_MANUAL_EN
    man_en = 1'b0;
    man_sel = '0;
`endif
    test_reset();
    test_scan();
    test_lock();
    test_mux();
    test_short_dropout();
    test_long_dropout();
    test_lock_at_timeout();
    test_mid_reset();
`ifdef AES3_SCAN_MANUAL_EN
    test_manual();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
